// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the data-memory responder: FSM encoding,
// latency bounds and the address-error decode.
package dmem_responder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam int LATENCY_MIN = 1;
    localparam int LATENCY_MAX = 15;
    localparam int CNT_W       = 4;
    localparam int ADDR_MAX_W  = 64;

    // Misaligned, or any bit set above the word-index field within addr_w bits.
    function automatic logic addr_err(input logic [ADDR_MAX_W-1:0] addr,
                                      input int addr_w,
                                      input int idx_w);
        logic err;
        err = (addr[1:0] != 2'b00);
        for (int b = 2; b < ADDR_MAX_W; b++) begin
            if (b >= idx_w + 2 && b < addr_w && addr[b]) begin
                err = 1'b1;
            end
        end
        return err;
    endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Load/store request channel between the pipeline (master) and the
// data-memory responder (slave).
interface dmem_responder_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_write;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic                  resp_valid;
    logic [DATA_WIDTH-1:0] resp_rdata;
    logic                  resp_err;
    logic                  busy;

    modport master (
        output req_valid, req_write, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_err, busy
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_err, busy
    );
endinterface

// File: rtl/dmem_responder_array.sv
// Word storage with synchronous write and a full clear on reset; the read
// port is combinational so the responder can register it on the RESP edge.
module dmem_array #(
    parameter int DATA_WIDTH  = 32,
    parameter int DEPTH_WORDS = 1024,
    parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [IDX_W-1:0]      wr_idx,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [IDX_W-1:0]      rd_idx,
    output logic [DATA_WIDTH-1:0] rd_data
);
    logic [DATA_WIDTH-1:0] mem_q [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH_WORDS; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en) begin
            mem_q[wr_idx] <= wr_data;
        end
    end

    assign rd_data = mem_q[rd_idx];

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder: one outstanding request, fixed latency,
// single-cycle response pulse, busy while a request is in flight.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 32,
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 3
) (
    input  logic            clk,
    input  logic            rst,
    dmem_responder_if.slave bus
);
    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

    if (LATENCY < LATENCY_MIN || LATENCY > LATENCY_MAX) begin : g_bad_latency
        $error("dmem_responder: LATENCY %0d outside %0d..%0d", LATENCY, LATENCY_MIN, LATENCY_MAX);
    end
    if (DEPTH_WORDS < 2 || (DEPTH_WORDS & (DEPTH_WORDS - 1)) != 0) begin : g_bad_depth
        $error("dmem_responder: DEPTH_WORDS %0d is not a power of two >= 2", DEPTH_WORDS);
    end
    if (ADDR_WIDTH > ADDR_MAX_W || ADDR_WIDTH < IDX_W + 2) begin : g_bad_addr
        $error("dmem_responder: ADDR_WIDTH %0d cannot hold the word index", ADDR_WIDTH);
    end

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  lat_write_q, lat_write_d;
    logic [ADDR_WIDTH-1:0] lat_addr_q, lat_addr_d;
    logic [DATA_WIDTH-1:0] lat_wdata_q, lat_wdata_d;
    logic                  resp_valid_q, resp_valid_d;
    logic [DATA_WIDTH-1:0] resp_rdata_q, resp_rdata_d;
    logic                  resp_err_q, resp_err_d;
    logic                  req_ready_q, req_ready_d;
    logic                  busy_q, busy_d;

    logic                  cur_write;
    logic [ADDR_WIDTH-1:0] cur_addr;
    logic [DATA_WIDTH-1:0] cur_wdata;
    logic                  cur_err;
    logic                  enter_resp;
    logic                  mem_wr_en;
    logic [IDX_W-1:0]      mem_idx;
    logic [DATA_WIDTH-1:0] mem_rdata;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        lat_write_d  = lat_write_q;
        lat_addr_d   = lat_addr_q;
        lat_wdata_d  = lat_wdata_q;
        enter_resp   = 1'b0;

        // With LATENCY = 1 the request goes straight to RESP from the bus, so
        // the memory access uses the live inputs instead of the latches.
        cur_write = (state_q == IDLE) ? bus.req_write : lat_write_q;
        cur_addr  = (state_q == IDLE) ? bus.req_addr  : lat_addr_q;
        cur_wdata = (state_q == IDLE) ? bus.req_wdata : lat_wdata_q;

        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    lat_write_d = bus.req_write;
                    lat_addr_d  = bus.req_addr;
                    lat_wdata_d = bus.req_wdata;
                    cnt_d       = CNT_LOAD;
                    if (LATENCY == 1) begin
                        state_d    = RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    state_d    = RESP;
                    enter_resp = 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        cur_err      = addr_err(ADDR_MAX_W'(cur_addr), ADDR_WIDTH, IDX_W);
        mem_idx      = cur_addr[IDX_W+1:2];
        mem_wr_en    = enter_resp && cur_write && !cur_err;

        resp_valid_d = enter_resp;
        resp_err_d   = enter_resp && cur_err;
        resp_rdata_d = (enter_resp && !cur_write && !cur_err) ? mem_rdata : '0;
        req_ready_d  = (state_d == IDLE);
        busy_d       = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            lat_write_q  <= 1'b0;
            lat_addr_q   <= '0;
            lat_wdata_q  <= '0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
            req_ready_q  <= 1'b1;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            lat_write_q  <= lat_write_d;
            lat_addr_q   <= lat_addr_d;
            lat_wdata_q  <= lat_wdata_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
            req_ready_q  <= req_ready_d;
            busy_q       <= busy_d;
        end
    end

    dmem_array #(
        .DATA_WIDTH  (DATA_WIDTH),
        .DEPTH_WORDS (DEPTH_WORDS),
        .IDX_W       (IDX_W)
    ) u_array (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (mem_wr_en),
        .wr_idx  (mem_idx),
        .wr_data (cur_wdata),
        .rd_idx  (mem_idx),
        .rd_data (mem_rdata)
    );

    assign bus.req_ready  = req_ready_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_rdata = resp_rdata_q;
    assign bus.resp_err   = resp_err_q;
    assign bus.busy       = busy_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: a LATENCY=3 instance for the main
// scenarios and a LATENCY=1 instance for back-to-back throughput.
module tb_dmem_responder;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    dmem_responder_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) if3 ();
    dmem_responder_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) if1 ();

    dmem_responder #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH_WORDS(1024), .LATENCY(3)) dut3 (
        .clk (clk),
        .rst (rst),
        .bus (if3)
    );

    dmem_responder #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH_WORDS(1024), .LATENCY(1)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (if1)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drives one request into the LATENCY=3 instance and records what came back.
    task automatic run_req3(input logic w, input logic [31:0] a, input logic [31:0] d,
                            output int lat, output int ready_low,
                            output logic [31:0] rd, output logic er,
                            output logic after_valid, output logic after_ready);
        lat = -1; ready_low = 0; rd = '0; er = 1'b0;
        for (int k = 0; k < 20 && !if3.req_ready; k++) step();
        if3.req_valid = 1'b1; if3.req_write = w; if3.req_addr = a; if3.req_wdata = d;
        step();
        if3.req_valid = 1'b0; if3.req_write = 1'b0; if3.req_addr = '0; if3.req_wdata = '0;
        for (int k = 1; k <= 20; k++) begin
            if (!if3.req_ready) ready_low++;
            if (if3.resp_valid) begin
                lat = k; rd = if3.resp_rdata; er = if3.resp_err;
                break;
            end
            step();
        end
        step();
        after_valid = if3.resp_valid;
        after_ready = if3.req_ready;
        $display("txn w=%0d addr=%08h wdata=%08h -> lat=%0d rdata=%08h err=%0d", w, a, d, lat, rd, er);
    endtask

    task automatic test_reset();
        int lat, rl; logic [31:0] rd; logic er, av, ar;
        rst = 1'b0;
        if3.req_valid = 0; if3.req_write = 0; if3.req_addr = '0; if3.req_wdata = '0;
        if1.req_valid = 0; if1.req_write = 0; if1.req_addr = '0; if1.req_wdata = '0;
        repeat (3) step();
        rst = 1'b1;
        step();
        n_cmp++; if (if3.req_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %0b want 1", if3.req_ready); end
        n_cmp++; if (if3.busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %0b want 0", if3.busy); end
        n_cmp++; if (if3.resp_valid !== 1'b0) begin n_bad++; $display("FAIL reset_resp_valid: got %0b want 0", if3.resp_valid); end
        n_cmp++; if (if3.resp_rdata !== 32'h0) begin n_bad++; $display("FAIL reset_rdata: got %08h want 0", if3.resp_rdata); end
        n_cmp++; if (if3.resp_err !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %0b want 0", if3.resp_err); end
        n_cmp++; if (if1.req_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready_l1: got %0b want 1", if1.req_ready); end
        run_req3(1'b0, 32'h0000_0010, 32'h0, lat, rl, rd, er, av, ar);
        n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL reset_load_lat: got %0d want 3", lat); end
        n_cmp++; if (rd !== 32'h0) begin n_bad++; $display("FAIL reset_load_rdata: got %08h want 0", rd); end
        n_cmp++; if (er !== 1'b0) begin n_bad++; $display("FAIL reset_load_err: got %0b want 0", er); end
    endtask

    task automatic test_store_load();
        int lat, rl; logic [31:0] rd; logic er, av, ar;
        run_req3(1'b1, 32'h0000_0040, 32'hDEAD_BEEF, lat, rl, rd, er, av, ar);
        n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL store_lat: got %0d want 3", lat); end
        n_cmp++; if (rl !== 3) begin n_bad++; $display("FAIL store_ready_low: got %0d want 3", rl); end
        n_cmp++; if (rd !== 32'h0) begin n_bad++; $display("FAIL store_rdata: got %08h want 0", rd); end
        n_cmp++; if (er !== 1'b0) begin n_bad++; $display("FAIL store_err: got %0b want 0", er); end
        n_cmp++; if (av !== 1'b0) begin n_bad++; $display("FAIL store_single_pulse: got %0b want 0", av); end
        n_cmp++; if (ar !== 1'b1) begin n_bad++; $display("FAIL store_ready_after: got %0b want 1", ar); end
        run_req3(1'b0, 32'h0000_0040, 32'h0, lat, rl, rd, er, av, ar);
        n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL load_lat: got %0d want 3", lat); end
        n_cmp++; if (rd !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL load_rdata: got %08h want deadbeef", rd); end
        n_cmp++; if (er !== 1'b0) begin n_bad++; $display("FAIL load_err: got %0b want 0", er); end
    endtask

    task automatic test_misaligned();
        int lat, rl; logic [31:0] rd; logic er, av, ar;
        run_req3(1'b1, 32'h0000_0042, 32'h0000_1234, lat, rl, rd, er, av, ar);
        n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL mis_store_lat: got %0d want 3", lat); end
        n_cmp++; if (er !== 1'b1) begin n_bad++; $display("FAIL mis_store_err: got %0b want 1", er); end
        n_cmp++; if (rd !== 32'h0) begin n_bad++; $display("FAIL mis_store_rdata: got %08h want 0", rd); end
        run_req3(1'b0, 32'h0000_0040, 32'h0, lat, rl, rd, er, av, ar);
        n_cmp++; if (rd !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL mis_no_write: got %08h want deadbeef", rd); end
        run_req3(1'b0, 32'h0000_0041, 32'h0, lat, rl, rd, er, av, ar);
        n_cmp++; if (er !== 1'b1) begin n_bad++; $display("FAIL mis_load_err: got %0b want 1", er); end
        n_cmp++; if (rd !== 32'h0) begin n_bad++; $display("FAIL mis_load_rdata: got %08h want 0", rd); end
    endtask

    task automatic test_out_of_range();
        int lat, rl; logic [31:0] rd; logic er, av, ar;
        run_req3(1'b0, 32'h0000_1000, 32'h0, lat, rl, rd, er, av, ar);
        n_cmp++; if (er !== 1'b1) begin n_bad++; $display("FAIL oor_load_err: got %0b want 1", er); end
        n_cmp++; if (rd !== 32'h0) begin n_bad++; $display("FAIL oor_load_rdata: got %08h want 0", rd); end
        run_req3(1'b0, 32'h8000_0040, 32'h0, lat, rl, rd, er, av, ar);
        n_cmp++; if (er !== 1'b1) begin n_bad++; $display("FAIL oor_msb_err: got %0b want 1", er); end
        n_cmp++; if (rd !== 32'h0) begin n_bad++; $display("FAIL oor_msb_rdata: got %08h want 0", rd); end
        run_req3(1'b1, 32'h0000_1040, 32'h0000_0BAD, lat, rl, rd, er, av, ar);
        n_cmp++; if (er !== 1'b1) begin n_bad++; $display("FAIL oor_store_err: got %0b want 1", er); end
        run_req3(1'b0, 32'h0000_0040, 32'h0, lat, rl, rd, er, av, ar);
        n_cmp++; if (rd !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL oor_no_alias: got %08h want deadbeef", rd); end
        run_req3(1'b1, 32'h0000_0FFC, 32'hCAFE_F00D, lat, rl, rd, er, av, ar);
        n_cmp++; if (er !== 1'b0) begin n_bad++; $display("FAIL top_store_err: got %0b want 0", er); end
        run_req3(1'b0, 32'h0000_0FFC, 32'h0, lat, rl, rd, er, av, ar);
        n_cmp++; if (rd !== 32'hCAFE_F00D) begin n_bad++; $display("FAIL top_load_rdata: got %08h want cafef00d", rd); end
        n_cmp++; if (er !== 1'b0) begin n_bad++; $display("FAIL top_load_err: got %0b want 0", er); end
    endtask

    task automatic test_reset_mid();
        int lat, rl, seen; logic [31:0] rd; logic er, av, ar;
        if3.req_valid = 1'b1; if3.req_write = 1'b1; if3.req_addr = 32'h0; if3.req_wdata = 32'h5555_AAAA;
        step();
        if3.req_valid = 1'b0; if3.req_write = 1'b0; if3.req_wdata = '0;
        $display("txn w=1 addr=00000000 wdata=5555aaaa accepted, reset in WAIT");
        n_cmp++; if (if3.busy !== 1'b1) begin n_bad++; $display("FAIL mid_busy_before: got %0b want 1", if3.busy); end
        rst = 1'b0;
        step();
        n_cmp++; if (if3.busy !== 1'b0) begin n_bad++; $display("FAIL mid_busy_reset: got %0b want 0", if3.busy); end
        n_cmp++; if (if3.req_ready !== 1'b1) begin n_bad++; $display("FAIL mid_ready_reset: got %0b want 1", if3.req_ready); end
        rst = 1'b1;
        seen = 0;
        for (int k = 0; k < 5; k++) begin
            if (if3.resp_valid) seen++;
            step();
        end
        n_cmp++; if (seen !== 0) begin n_bad++; $display("FAIL mid_no_resp: got %0d pulses want 0", seen); end
        run_req3(1'b0, 32'h0000_0000, 32'h0, lat, rl, rd, er, av, ar);
        n_cmp++; if (rd !== 32'h0) begin n_bad++; $display("FAIL mid_load0: got %08h want 0", rd); end
        n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL mid_load0_lat: got %0d want 3", lat); end
        run_req3(1'b0, 32'h0000_0040, 32'h0, lat, rl, rd, er, av, ar);
        n_cmp++; if (rd !== 32'h0) begin n_bad++; $display("FAIL mid_cleared: got %08h want 0", rd); end
    endtask

    task automatic test_back_to_back();
        logic        op_w  [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        logic [31:0] op_d  [4] = '{32'hA5A5_0001, 32'h0, 32'h0F0F_1234, 32'h0};
        logic [31:0] exp_rd[4] = '{32'h0, 32'hA5A5_0001, 32'h0, 32'h0F0F_1234};
        int idx = 0, nacc = 0, nresp = 0;
        logic acc;
        if1.req_valid = 1'b1; if1.req_write = op_w[0]; if1.req_addr = 32'h4; if1.req_wdata = op_d[0];
        for (int c = 0; c < 8; c++) begin
            n_cmp++; if (if1.req_ready !== (c % 2 == 0)) begin n_bad++; $display("FAIL b2b_ready c%0d: got %0b want %0b", c, if1.req_ready, (c % 2 == 0)); end
            n_cmp++; if (if1.resp_valid !== (c % 2 == 1)) begin n_bad++; $display("FAIL b2b_valid c%0d: got %0b want %0b", c, if1.resp_valid, (c % 2 == 1)); end
            if (if1.resp_valid && nresp < 4) begin
                $display("txn b2b resp %0d rdata=%08h err=%0d", nresp, if1.resp_rdata, if1.resp_err);
                n_cmp++; if (if1.resp_rdata !== exp_rd[nresp]) begin n_bad++; $display("FAIL b2b_rdata %0d: got %08h want %08h", nresp, if1.resp_rdata, exp_rd[nresp]); end
                n_cmp++; if (if1.resp_err !== 1'b0) begin n_bad++; $display("FAIL b2b_err %0d: got %0b want 0", nresp, if1.resp_err); end
            end
            if (if1.resp_valid) nresp++;
            acc = if1.req_ready;
            step();
            if (acc) begin
                nacc++;
                idx++;
                if (idx < 4) begin
                    if1.req_write = op_w[idx]; if1.req_wdata = op_d[idx];
                end
            end
        end
        if1.req_valid = 1'b0; if1.req_write = 1'b0; if1.req_wdata = '0;
        n_cmp++; if (nacc !== 4) begin n_bad++; $display("FAIL b2b_accepts: got %0d want 4", nacc); end
        n_cmp++; if (nresp !== 4) begin n_bad++; $display("FAIL b2b_responses: got %0d want 4", nresp); end
    endtask

    initial begin
        test_reset();
        test_store_load();
        test_misaligned();
        test_out_of_range();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
